// File: rtl/pw_pkg.sv
// Shared definitions for the password checker slice.
// Holds the candidate geometry (bytes, bit width, length-field width) and the
// checker FSM state encoding. No ports; imported by the interface and the top.
package pw_pkg;

  localparam int PW_BYTES = 16;
  localparam int PW_W     = 8 * PW_BYTES;
  localparam int LEN_W    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } pw_state_t;

endpackage

// File: rtl/password_checker_if.sv
// Candidate link between the brute-force generator (master) and the
// password checker (slave).
//   cand_password : candidate, byte 0 = bits[7:0] = first character
//   cand_length   : candidate length in bits
//   ready         : driven by the checker
//
// Handshake: the generator always presents a valid candidate, so there is no
// separate valid. A candidate is transferred on every rising clock edge at
// which ready is 1; the generator must then present the next candidate before
// the following edge. When ready is 0 the candidate is ignored and the
// generator holds it.
interface password_checker_if;
  import pw_pkg::*;

  logic [PW_W-1:0]  cand_password;
  logic [LEN_W-1:0] cand_length;
  logic             ready;

  modport master (output cand_password, output cand_length, input ready);
  modport slave  (input cand_password, input cand_length, output ready);

endinterface

// File: rtl/pw_byte_compare.sv
// Combinational first-stage compare for the password checker.
// Ports:
//   cand_password / cand_length     : candidate held in pipeline stage S1
//   target_password / target_length : latched target
//   eq     : per-byte equality, eq[i] = (cand byte i == target byte i)
//   mask   : mask[i] = (i < target_length/8), the bytes that take part
//   len_ok : lengths equal and the target length is legal
//            (non-zero, multiple of 8, not above 8*PW_BYTES)
module pw_byte_compare #(
  parameter int PW_BYTES = 16
) (
  input  logic [8*PW_BYTES-1:0] cand_password,
  input  logic [7:0]            cand_length,
  input  logic [8*PW_BYTES-1:0] target_password,
  input  logic [7:0]            target_length,
  output logic [PW_BYTES-1:0]   eq,
  output logic [PW_BYTES-1:0]   mask,
  output logic                  len_ok
);

  logic len_legal;

  always_comb begin
    eq   = '0;
    mask = '0;
    for (int i = 0; i < PW_BYTES; i++) begin
      eq[i]   = (cand_password[8*i +: 8] == target_password[8*i +: 8]);
      mask[i] = (i < (int'(target_length) / 8));
    end
  end

  // An illegal target length can never be matched, so the search runs out.
  assign len_legal = (target_length != 8'd0) &&
                     (target_length[2:0] == 3'd0) &&
                     (int'(target_length) <= 8 * PW_BYTES);

  assign len_ok = len_legal && (cand_length == target_length);

endmodule

// File: rtl/password_checker.sv
// Password checker: consumes generator candidates one per clock, compares each
// against a target latched at search start in a two-stage pipeline, and
// reports found / exhausted with the winning password and attempt count.
// Ports:
//   clock, resetn      : rising-edge clock, asynchronous active-low reset
//   enable             : 0->1 outside RUN starts a search; 0 in RUN aborts
//   target_password    : target, latched at start
//   target_length      : target length in bits, latched at start
//   cand               : candidate link (slave side), ready is registered
//   busy               : high in RUN
//   found, exhausted   : sticky result flags, cleared by the next start
//   match_password     : matching candidate, valid while found = 1
//   attempts           : candidates decided in the current search
//   dbg_state          : current FSM state
module password_checker
  import pw_pkg::*;
#(
  parameter int                   ATTEMPT_W    = 32,
  parameter logic [ATTEMPT_W-1:0] MAX_ATTEMPTS = {ATTEMPT_W{1'b1}}
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [PW_W-1:0]      target_password,
  input  logic [LEN_W-1:0]     target_length,
  password_checker_if.slave    cand,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [PW_W-1:0]      match_password,
  output logic [ATTEMPT_W-1:0] attempts,
  output pw_state_t            dbg_state
);

  pw_state_t state, state_next;

  logic                 enable_q;
  logic                 ready_q, ready_next;
  logic [ATTEMPT_W-1:0] issued, issued_next;
  logic [ATTEMPT_W-1:0] attempts_next;
  logic [PW_W-1:0]      tgt_pw;
  logic [LEN_W-1:0]     tgt_len;

  // Stage S1: raw sampled candidate.
  logic                 s1_valid;
  logic [PW_W-1:0]      s1_pw;
  logic [LEN_W-1:0]     s1_len;

  // Stage S2: compare results plus the candidate for match_password.
  logic                 s2_valid;
  logic [PW_W-1:0]      s2_pw;
  logic [PW_BYTES-1:0]  s2_eq, s2_mask;
  logic                 s2_len_ok;

  logic [PW_BYTES-1:0]  cmp_eq, cmp_mask;
  logic                 cmp_len_ok;

  logic rise, start, abort, sample, hit, give_up, match;

  pw_byte_compare #(.PW_BYTES(PW_BYTES)) u_cmp (
    .cand_password   (s1_pw),
    .cand_length     (s1_len),
    .target_password (tgt_pw),
    .target_length   (tgt_len),
    .eq              (cmp_eq),
    .mask            (cmp_mask),
    .len_ok          (cmp_len_ok)
  );

  always_comb begin
    state_next    = state;
    issued_next   = issued;
    attempts_next = attempts;
    ready_next    = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    sample        = 1'b0;
    hit           = 1'b0;
    give_up       = 1'b0;
    rise          = enable & ~enable_q;
    // Bytes beyond the target length are don't-care.
    match         = s2_len_ok & (&(s2_eq | ~s2_mask));

    unique case (state)
      IDLE, FOUND, EXHAUSTED: begin
        if (rise) begin
          start         = 1'b1;
          state_next    = RUN;
          issued_next   = '0;
          attempts_next = '0;
          ready_next    = (MAX_ATTEMPTS != '0);
        end
      end
      RUN: begin
        if (!enable) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          sample = ready_q;
          if (sample && (issued != MAX_ATTEMPTS))
            issued_next = issued + ATTEMPT_W'(1);
          if (s2_valid) begin
            if (attempts != MAX_ATTEMPTS)
              attempts_next = attempts + ATTEMPT_W'(1);
            // A match on the limiting decision still counts as found.
            if (match) begin
              hit        = 1'b1;
              state_next = FOUND;
            end else if (attempts_next == MAX_ATTEMPTS) begin
              give_up    = 1'b1;
              state_next = EXHAUSTED;
            end
          end
          // ready drops on the same edge issued reaches the limit.
          ready_next = (state_next == RUN) && (issued_next < MAX_ATTEMPTS);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      // Treat enable as already high so a level held through reset is not a start.
      enable_q       <= 1'b1;
      ready_q        <= 1'b0;
      issued         <= '0;
      attempts       <= '0;
      found          <= 1'b0;
      exhausted      <= 1'b0;
      match_password <= '0;
      tgt_pw         <= '0;
      tgt_len        <= '0;
      s1_valid       <= 1'b0;
      s1_pw          <= '0;
      s1_len         <= '0;
      s2_valid       <= 1'b0;
      s2_pw          <= '0;
      s2_eq          <= '0;
      s2_mask        <= '0;
      s2_len_ok      <= 1'b0;
    end else begin
      state    <= state_next;
      enable_q <= enable;
      ready_q  <= ready_next;
      issued   <= issued_next;
      attempts <= attempts_next;

      if (start) begin
        found          <= 1'b0;
        exhausted      <= 1'b0;
        match_password <= '0;
        tgt_pw         <= target_password;
        tgt_len        <= target_length;
      end
      if (abort) begin
        found     <= 1'b0;
        exhausted <= 1'b0;
      end
      if (hit) begin
        found          <= 1'b1;
        match_password <= s2_pw;
      end
      if (give_up)
        exhausted <= 1'b1;

      // Leaving RUN flushes both stages; in-flight candidates are never decided.
      s1_valid <= sample && (state_next == RUN);
      if (sample) begin
        s1_pw  <= cand.cand_password;
        s1_len <= cand.cand_length;
      end
      s2_valid  <= s1_valid && (state_next == RUN);
      s2_pw     <= s1_pw;
      s2_eq     <= cmp_eq;
      s2_mask   <= cmp_mask;
      s2_len_ok <= cmp_len_ok;
    end
  end

  assign cand.ready = ready_q;
  assign busy       = (state == RUN);
  assign dbg_state  = state;

endmodule

// File: tb/tb_password_checker.sv
// Self-checking bench for password_checker with MAX_ATTEMPTS = 5.
module tb_password_checker;
  import pw_pkg::*;

  localparam int             AW   = 32;
  localparam logic [AW-1:0]  MAXA = 32'd5;
  localparam int             EW   = 2 + AW + PW_W;

  logic              clock = 1'b0;
  logic              resetn;
  logic              enable;
  logic [PW_W-1:0]   target_password;
  logic [LEN_W-1:0]  target_length;
  logic              busy, found, exhausted;
  logic [PW_W-1:0]   match_password;
  logic [AW-1:0]     attempts;
  pw_state_t         dbg_state;

  password_checker_if cif ();

  password_checker #(.ATTEMPT_W(AW), .MAX_ATTEMPTS(MAXA)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .target_password (target_password),
    .target_length   (target_length),
    .cand            (cif),
    .busy            (busy),
    .found           (found),
    .exhausted       (exhausted),
    .match_password  (match_password),
    .attempts        (attempts),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];

  logic [PW_W-1:0]  cand_pw[16];
  logic [LEN_W-1:0] cand_len[16];

  localparam logic [PW_W-1:0] AB    = 128'h6261;
  localparam logic [PW_W-1:0] AB_HI = {{14{8'hFF}}, 16'h6261};

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic f, input logic x,
                                           input logic [AW-1:0] att, input logic [PW_W-1:0] pw);
    return {f, x, att, pw};
  endfunction

  // Monitor: pops one expected result whenever found or exhausted rises.
  logic found_d = 1'b0;
  logic exh_d   = 1'b0;
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if ((found && !found_d) || (exhausted && !exh_d)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: found=%0b exhausted=%0b attempts=%0d", found, exhausted, attempts);
      end else begin
        e = exp_q.pop_front();
        check("res_found",     EW'(found),          EW'(e[EW-1]));
        check("res_exhausted", EW'(exhausted),      EW'(e[EW-2]));
        check("res_attempts",  EW'(attempts),       EW'(e[PW_W +: AW]));
        check("res_match_pw",  EW'(match_password), EW'(e[PW_W-1:0]));
      end
    end
    found_d <= found;
    exh_d   <= exhausted;
  end

  // ---------------- driver tasks ----------------
  task automatic start(input logic [PW_W-1:0] tpw, input logic [LEN_W-1:0] tlen);
    @(negedge clock);
    enable          = 1'b0;
    target_password = tpw;
    target_length   = tlen;
    @(negedge clock);
    enable = 1'b1;
  endtask

  // Acts as the generator: presents cand_pw[idx] before each edge with ready=1.
  // Returns when a result appears or after max_s candidates were presented.
  task automatic feed(input int max_s, output int n_rdy);
    int idx;
    idx   = 0;
    n_rdy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (found || exhausted) return;
      if (cif.ready) begin
        cif.cand_password = cand_pw[idx];
        cif.cand_length   = cand_len[idx];
        idx++;
        n_rdy++;
        if (idx == max_s) return;
      end
    end
    n_total++;
    $display("FAIL feed_timeout: got no result after 200 cycles, expected a result");
  endtask

  task automatic set_cand(input int i, input logic [PW_W-1:0] pw, input logic [LEN_W-1:0] len);
    cand_pw[i]  = pw;
    cand_len[i] = len;
  endtask

  task automatic fill_nomatch();
    for (int i = 0; i < 16; i++) set_cand(i, 128'h7A7A + PW_W'(i), 8'd16);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    resetn              = 1'b0;
    enable              = 1'b0;
    target_password     = '0;
    target_length       = '0;
    cif.cand_password   = '0;
    cif.cand_length     = '0;

    #12;
    check("rst_ready",     EW'(cif.ready),      EW'(0));
    check("rst_busy",      EW'(busy),           EW'(0));
    check("rst_found",     EW'(found),          EW'(0));
    check("rst_exhausted", EW'(exhausted),      EW'(0));
    check("rst_attempts",  EW'(attempts),       EW'(0));
    check("rst_match_pw",  EW'(match_password), EW'(0));
    check("rst_state",     EW'(dbg_state),      EW'(IDLE));
    @(negedge clock);
    resetn = 1'b1;

    // Basic find: C4 matches, C5 sampled but never decided.
    fill_nomatch();
    set_cand(0, 128'h6161, 8'd16);
    set_cand(1, 128'h6262, 8'd16);
    set_cand(2, 128'h61,   8'd8);
    set_cand(3, AB,        8'd16);
    set_cand(4, 128'h6263, 8'd16);
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd4, AB));
    start(AB, 8'd16);
    feed(16, n);
    check("t1_ready_cycles", EW'(n), EW'(5));
    // enable stays high: no restart, flags and count hold.
    repeat (4) @(negedge clock);
    check("t1_no_restart_busy", EW'(busy),      EW'(0));
    check("t1_ready_low",       EW'(cif.ready), EW'(0));
    check("t1_found_sticky",    EW'(found),     EW'(1));
    check("t1_attempts_held",   EW'(attempts),  EW'(4));

    // Length mismatch, then a match whose upper bytes are ignored.
    fill_nomatch();
    set_cand(0, AB,    8'd24);
    set_cand(1, AB_HI, 8'd16);
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd2, AB_HI));
    start(AB, 8'd16);
    feed(16, n);
    check("t2_ready_cycles", EW'(n), EW'(4));

    // Exhaustion: five misses.
    fill_nomatch();
    exp_q.push_back(mk_exp(1'b0, 1'b1, 32'd5, '0));
    start(AB, 8'd16);
    feed(16, n);
    check("t3_ready_cycles", EW'(n), EW'(5));

    // Match on the decision that reaches the limit: found wins.
    fill_nomatch();
    set_cand(4, AB, 8'd16);
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd5, AB));
    start(AB, 8'd16);
    feed(16, n);
    check("t4_ready_cycles", EW'(n), EW'(5));

    // Illegal target length (12 bits) never matches, even an equal length.
    for (int i = 0; i < 16; i++) set_cand(i, AB, 8'd12);
    exp_q.push_back(mk_exp(1'b0, 1'b1, 32'd5, '0));
    start(AB, 8'd12);
    feed(16, n);
    check("t5_ready_cycles", EW'(n), EW'(5));

    // Abort after three samples: only C1 was decided before the abort edge.
    fill_nomatch();
    start(AB, 8'd16);
    feed(3, n);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("ab_busy",      EW'(busy),      EW'(0));
    check("ab_ready",     EW'(cif.ready), EW'(0));
    check("ab_found",     EW'(found),     EW'(0));
    check("ab_exhausted", EW'(exhausted), EW'(0));
    check("ab_attempts",  EW'(attempts),  EW'(1));
    check("ab_state",     EW'(dbg_state), EW'(IDLE));

    // Restart: counters cleared, first candidate matches.
    set_cand(0, AB, 8'd16);
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd1, AB));
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    #1;
    check("rs_attempts_cleared", EW'(attempts), EW'(0));
    check("rs_busy",             EW'(busy),     EW'(1));
    feed(16, n);
    check("rs_ready_cycles", EW'(n), EW'(3));

    // Asynchronous reset between edges in the middle of a search.
    fill_nomatch();
    start(AB, 8'd16);
    feed(4, n);
    @(posedge clock);
    #1;
    check("ar_attempts_before", EW'(attempts), EW'(2));
    #2;
    resetn = 1'b0;
    #1;
    check("ar_ready",     EW'(cif.ready),      EW'(0));
    check("ar_busy",      EW'(busy),           EW'(0));
    check("ar_found",     EW'(found),          EW'(0));
    check("ar_exhausted", EW'(exhausted),      EW'(0));
    check("ar_attempts",  EW'(attempts),       EW'(0));
    check("ar_match_pw",  EW'(match_password), EW'(0));
    check("ar_state",     EW'(dbg_state),      EW'(IDLE));
    @(negedge clock);
    resetn = 1'b1;
    // enable is still high: no start without a fresh rising edge.
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("ar_idle_busy",  EW'(busy),      EW'(0));
      check("ar_idle_ready", EW'(cif.ready), EW'(0));
    end

    repeat (3) @(negedge clock);
    check("queue_drained", EW'(exp_q.size()), EW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
